// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command frame receiver.
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CRC     = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle counter: clears on demand, counts while enabled and
// flags the terminal count TIMEOUT_CYC-1.
module frame_timeout_cnt #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_reg;

  // Saturates at the terminal count so the flag stays stable until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !tc) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign tc = (cnt_reg == TC_VAL);

endmodule

// File: rtl/cmd_frame_parser.sv
// Byte-level command frame receiver: delimits frames, steers the external
// crc8, buffers the payload and releases it only on a CRC match.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 crc_en,
  output logic                 crc_clr,
  output logic [7:0]           crc_data,
  input  logic [7:0]           crc_value,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_id,
  output logic [3:0]           cmd_len,
  output logic [MAX_LEN*8-1:0] cmd_payload,
  output logic                 frame_err,
  output logic [1:0]           err_code
);

  state_t state_reg, state_next;

  logic [7:0]           id_reg;
  logic [3:0]           len_reg;
  logic [3:0]           idx_reg;
  logic [MAX_LEN*8-1:0] pay_flat;

  logic                 cmd_valid_reg;
  logic [7:0]           cmd_id_reg;
  logic [3:0]           cmd_len_reg;
  logic [MAX_LEN*8-1:0] cmd_payload_reg;
  logic                 frame_err_reg;
  logic [1:0]           err_code_reg;

  logic       len_load;
  logic       pay_wr;
  logic       ok_next;
  logic       err_next;
  logic [1:0] err_code_next;
  logic       tmo_tc;
  logic       tmo_hit;

  frame_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (rx_valid || (state_reg == ST_IDLE)),
    .en  (state_reg != ST_IDLE),
    .tc  (tmo_tc)
  );

  // A byte arriving on the terminal cycle takes priority over the timeout.
  assign tmo_hit  = tmo_tc && !rx_valid && (state_reg != ST_IDLE);
  assign crc_data = rx_data;

  always_comb begin
    state_next    = state_reg;
    crc_en        = 1'b0;
    crc_clr       = 1'b0;
    len_load      = 1'b0;
    pay_wr        = 1'b0;
    ok_next       = 1'b0;
    err_next      = 1'b0;
    err_code_next = ERR_NONE;
    case (state_reg)
      ST_IDLE: begin
        crc_clr = 1'b1;
        if (rx_valid && (rx_data == HEADER)) state_next = ST_CMD;
      end
      ST_CMD: begin
        if (rx_valid) begin
          crc_en     = 1'b1;
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          crc_en = 1'b1;
          if (rx_data > 8'(MAX_LEN)) begin
            err_next      = 1'b1;
            err_code_next = ERR_LEN;
            state_next    = ST_IDLE;
          end else begin
            len_load   = 1'b1;
            state_next = (rx_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          crc_en = 1'b1;
          pay_wr = 1'b1;
          if (idx_reg == len_reg - 4'd1) state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // crc_value already folds in the last payload byte here.
        if (rx_valid) begin
          if (rx_data == crc_value) begin
            ok_next = 1'b1;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_CRC;
          end
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (tmo_hit) begin
      err_next      = 1'b1;
      err_code_next = ERR_TIMEOUT;
      state_next    = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      id_reg          <= '0;
      len_reg         <= '0;
      idx_reg         <= '0;
      cmd_valid_reg   <= 1'b0;
      cmd_id_reg      <= '0;
      cmd_len_reg     <= '0;
      cmd_payload_reg <= '0;
      frame_err_reg   <= 1'b0;
      err_code_reg    <= ERR_NONE;
    end else begin
      state_reg     <= state_next;
      cmd_valid_reg <= ok_next;
      frame_err_reg <= err_next;
      if (err_next) err_code_reg <= err_code_next;
      if ((state_reg == ST_CMD) && rx_valid) id_reg <= rx_data;
      if (len_load) begin
        len_reg <= rx_data[3:0];
        idx_reg <= '0;
      end else if (pay_wr) begin
        idx_reg <= idx_reg + 4'd1;
      end
      if (ok_next) begin
        cmd_id_reg      <= id_reg;
        cmd_len_reg     <= len_reg;
        cmd_payload_reg <= pay_flat;
      end
    end
  end

  // Shadow payload: cleared at each LEN byte so unused slots read as zero.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pay
    logic [7:0] byte_reg;
    always_ff @(posedge clk) begin
      if (rst || len_load) begin
        byte_reg <= '0;
      end else if (pay_wr && (idx_reg == 4'(gi))) begin
        byte_reg <= rx_data;
      end
    end
    assign pay_flat[8*gi +: 8] = byte_reg;
  end

  assign cmd_valid   = cmd_valid_reg;
  assign cmd_id      = cmd_id_reg;
  assign cmd_len     = cmd_len_reg;
  assign cmd_payload = cmd_payload_reg;
  assign frame_err   = frame_err_reg;
  assign err_code    = err_code_reg;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser with a crc8 peripheral model and a
// frame-level reference model driving directed and random frames.
module tb_cmd_frame_parser;

  localparam int MAX_LEN = 8;
  localparam int TMO     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        crc_en, crc_clr;
  logic [7:0]  crc_data;
  logic [7:0]  crc_value;
  logic        cmd_valid, frame_err;
  logic [7:0]  cmd_id;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  cmd_frame_parser #(
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYC(TMO),
    .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .crc_en(crc_en), .crc_clr(crc_clr), .crc_data(crc_data), .crc_value(crc_value),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .frame_err(frame_err), .err_code(err_code)
  );

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // External crc8 block: updates one edge after crc_en.
  logic [7:0] crc_reg = 8'h00;
  always @(posedge clk) begin
    if (crc_clr) crc_reg <= 8'h00;
    else if (crc_en) crc_reg <= crc8_step(crc_reg, crc_data);
  end
  assign crc_value = crc_reg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int n_cmd = 0, n_err = 0, last_cmd_cyc = -1, last_err_cyc = -1, byte_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid) begin n_cmd++; last_cmd_cyc = cyc; end
    if (frame_err) begin n_err++; last_err_cyc = cyc; end
    if (cmd_valid || frame_err) chk("pulse_exclusive", 64'(cmd_valid & frame_err), 64'd0);
  end

  logic [7:0]  pl [16];
  logic [7:0]  exp_id = 8'h00;
  logic [3:0]  exp_len = 4'h0;
  logic [63:0] exp_pl = 64'h0;
  logic [1:0]  exp_code = 2'b00;

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    byte_cyc = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
    for (int k = 1; k < gap; k++) @(negedge clk);
  endtask

  function automatic logic [7:0] frame_crc(input logic [7:0] cmd, input int len);
    logic [7:0] c;
    c = crc8_step(8'h00, cmd);
    c = crc8_step(c, 8'(len));
    for (int i = 0; i < len; i++) c = crc8_step(c, pl[i]);
    return c;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_id"}, 64'(cmd_id), 64'(exp_id));
    chk({tag, "_len"}, 64'(cmd_len), 64'(exp_len));
    chk({tag, "_payload"}, cmd_payload, exp_pl);
    chk({tag, "_code"}, 64'(err_code), 64'(exp_code));
  endtask

  // Sends one complete frame and checks the outcome predicted from the frame rules.
  task automatic send_frame(input string tag, input logic [7:0] cmd, input int len,
                            input bit corrupt, input int gap);
    logic [7:0] q[$];
    logic [7:0] c;
    int c0, e0, kind;
    q.push_back(8'hA5);
    q.push_back(cmd);
    q.push_back(8'(len));
    if (len > MAX_LEN) begin
      kind = 2;
    end else begin
      for (int i = 0; i < len; i++) q.push_back(pl[i]);
      c = frame_crc(cmd, len);
      q.push_back(corrupt ? (c ^ 8'h01) : c);
      kind = corrupt ? 1 : 0;
    end
    c0 = n_cmd;
    e0 = n_err;
    for (int i = 0; i < q.size(); i++) send_byte(q[i], gap);
    repeat (3) @(negedge clk);
    if (kind == 0) begin
      exp_id  = cmd;
      exp_len = 4'(len);
      exp_pl  = 64'h0;
      for (int i = 0; i < len; i++) exp_pl[8*i +: 8] = pl[i];
      chk({tag, "_cmd_count"}, 64'(n_cmd - c0), 64'd1);
      chk({tag, "_err_count"}, 64'(n_err - e0), 64'd0);
      chk({tag, "_cmd_latency"}, 64'(last_cmd_cyc), 64'(byte_cyc));
    end else begin
      exp_code = (kind == 1) ? 2'b01 : 2'b10;
      chk({tag, "_cmd_count"}, 64'(n_cmd - c0), 64'd0);
      chk({tag, "_err_count"}, 64'(n_err - e0), 64'd1);
      chk({tag, "_err_latency"}, 64'(last_err_cyc), 64'(byte_cyc));
    end
    check_outputs(tag);
    $display("frame %s cmd=%02h len=%0d corrupt=%0d gap=%0d kind=%0d", tag, cmd, len, corrupt, gap, kind);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0, b;
    logic [7:0] c;

    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_crc_clr", 64'(crc_clr), 64'd1);
    chk("rst_crc_en", 64'(crc_en), 64'd0);
    check_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Good frame, bytes 3 clocks apart.
    pl[0] = 8'h3C; pl[1] = 8'h7E;
    send_frame("good", 8'h10, 2, 1'b0, 3);
    chk("good_payload_lit", cmd_payload, 64'h0000_0000_0000_7E3C);

    // Same frame with a corrupted CRC byte.
    send_frame("badcrc", 8'h10, 2, 1'b1, 3);

    // Oversized length, then a good frame.
    send_frame("badlen", 8'h20, 9, 1'b0, 1);
    pl[0] = 8'hA5;
    send_frame("after_len", 8'h33, 1, 1'b0, 2);

    // Two zero-length frames back-to-back; second HEADER lands on the pulse cycle.
    c0 = n_cmd;
    e0 = n_err;
    c = frame_crc(8'h05, 0);
    send_byte(8'hA5, 1); send_byte(8'h05, 1); send_byte(8'h00, 1); send_byte(c, 1);
    c = frame_crc(8'h06, 0);
    send_byte(8'hA5, 1); send_byte(8'h06, 1); send_byte(8'h00, 1); send_byte(c, 1);
    repeat (3) @(negedge clk);
    exp_id = 8'h06; exp_len = 4'h0; exp_pl = 64'h0;
    chk("zlen_cmd_count", 64'(n_cmd - c0), 64'd2);
    chk("zlen_err_count", 64'(n_err - e0), 64'd0);
    check_outputs("zlen");
    $display("frame zlen x2 back-to-back");

    // Timeout: stall after the CMD byte.
    c0 = n_cmd;
    e0 = n_err;
    send_byte(8'hA5, 1);
    send_byte(8'h11, 1);
    b = byte_cyc;
    for (int k = 0; k < 40 && n_err == e0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    exp_code = 2'b11;
    chk("tmo_err_count", 64'(n_err - e0), 64'd1);
    chk("tmo_cmd_count", 64'(n_cmd - c0), 64'd0);
    chk("tmo_latency", 64'(last_err_cyc), 64'(b + TMO));
    check_outputs("tmo");
    $display("timeout stall after cmd byte at cycle %0d", b);

    // Byte landing exactly on the terminal cycle is accepted.
    c0 = n_cmd;
    e0 = n_err;
    pl[0] = 8'h5A;
    c = frame_crc(8'h11, 1);
    send_byte(8'hA5, 1);
    send_byte(8'h11, TMO);
    send_byte(8'h01, 3);
    send_byte(8'h5A, 3);
    send_byte(c, 3);
    repeat (3) @(negedge clk);
    exp_id = 8'h11; exp_len = 4'h1; exp_pl = 64'h5A;
    chk("tmo_edge_err_count", 64'(n_err - e0), 64'd0);
    chk("tmo_edge_cmd_count", 64'(n_cmd - c0), 64'd1);
    check_outputs("tmo_edge");
    $display("timeout terminal-cycle byte accepted");

    // Garbage inside payload, then reset mid-frame.
    c0 = n_cmd;
    e0 = n_err;
    send_byte(8'hA5, 2); send_byte(8'h30, 2); send_byte(8'h04, 2);
    send_byte(8'h00, 2); send_byte(8'hFF, 2); send_byte(8'hA5, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_id = 8'h00; exp_len = 4'h0; exp_pl = 64'h0; exp_code = 2'b00;
    chk("midrst_cmd_count", 64'(n_cmd - c0), 64'd0);
    chk("midrst_err_count", 64'(n_err - e0), 64'd0);
    check_outputs("midrst");
    $display("reset mid-frame");
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_frame("after_rst", 8'h44, 3, 1'b0, 1);

    // Randomised frames.
    for (int n = 0; n < 30; n++) begin
      int len, r;
      r = int'($urandom_range(0, 9));
      len = (r == 9) ? int'($urandom_range(9, 255)) : r;
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      send_frame("rand", 8'($urandom), len, ($urandom_range(0, 3) == 0), int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
